// File: rtl/spi_input_frontend.sv
// spi_input_frontend
// Conditions the raw SPI pins (sclk, cs, mosi) for the downstream memory
// control FSM. Each pin passes through a two-flop synchronizer and a
// debounce counter. Clean levels and single-cycle edge strobes come out of
// that stage. The block also captures MOSI on each SCLK rising edge and
// tracks the bit and byte position inside a frame.
// Optional build macro: SPI_GLITCH_COUNT_EN adds an 8-bit saturating
// count of rejected pulses on the glitch_count port.
// Channel index inside the packed vectors: 0 = sclk, 1 = cs, 2 = mosi.

module spi_input_frontend #(
  parameter int WAIT_TIME = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       sclk_pos,
  output logic       sclk_neg,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       mosi_sample,
  output logic [2:0] bit_count,
  output logic       byte_done
`ifdef SPI_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int CNT_W = $clog2(WAIT_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIME - 1);
  // Idle pin levels: sclk low, cs high (deselected), mosi low.
  localparam logic [2:0] IDLE_LEVELS = 3'b010;

  logic [2:0]       sync0_r;
  logic [2:0]       sync1_r;
  logic [2:0]       cond_r;
  logic [CNT_W-1:0] cnt_r [3];

  logic [2:0] differ_s;
  logic [2:0] accept_s;
  logic [2:0] next_cond_s;
  logic       sclk_pos_s;

  // Decide, per channel, whether the synchronized level replaces the conditioned one.
  always_comb begin
    differ_s = 3'b000;
    accept_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      differ_s[i] = sync1_r[i] ^ cond_r[i];
      accept_s[i] = differ_s[i] && (cnt_r[i] == CNT_MAX);
    end
    next_cond_s = cond_r ^ accept_s;
    sclk_pos_s  = accept_s[0] & sync1_r[0];
  end

  // Synchronizers, debounce counters, conditioned levels, strobes and frame tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_r     <= IDLE_LEVELS;
      sync1_r     <= IDLE_LEVELS;
      cond_r      <= IDLE_LEVELS;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
      sclk_pos    <= 1'b0;
      sclk_neg    <= 1'b0;
      cs_fall     <= 1'b0;
      cs_rise     <= 1'b0;
      mosi_sample <= 1'b0;
      bit_count   <= 3'd0;
      byte_done   <= 1'b0;
    end else begin
      sync0_r <= {mosi_pin, cs_pin, sclk_pin};
      sync1_r <= sync0_r;
      cond_r  <= next_cond_s;
      for (int i = 0; i < 3; i++) begin
        if (differ_s[i] && !accept_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= '0;
        end
      end
      sclk_pos <= sclk_pos_s;
      sclk_neg <= accept_s[0] & ~sync1_r[0];
      cs_fall  <= accept_s[1] & ~sync1_r[1];
      cs_rise  <= accept_s[1] & sync1_r[1];
      // The sample is the conditioned MOSI visible alongside the sclk_pos strobe.
      if (sclk_pos_s) begin
        mosi_sample <= next_cond_s[2];
      end else begin
        mosi_sample <= mosi_sample;
      end
      // Deselect dominates: a cs rise on the same cycle as an SCLK edge clears the count.
      if (next_cond_s[1]) begin
        bit_count <= 3'd0;
        byte_done <= 1'b0;
      end else if (sclk_pos_s) begin
        bit_count <= bit_count + 3'd1;
        byte_done <= (bit_count == 3'd7);
      end else begin
        bit_count <= bit_count;
        byte_done <= 1'b0;
      end
    end
  end

  assign sclk = cond_r[0];
  assign cs   = cond_r[1];
  assign mosi = cond_r[2];

`ifdef SPI_GLITCH_COUNT_EN
  logic [2:0] reject_s;
  logic [1:0] reject_sum_s;

  // Saturating add of a small increment to the 8-bit glitch counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    if (sum > 9'd255) begin
      sat_add8 = 8'd255;
    end else begin
      sat_add8 = sum[7:0];
    end
  endfunction

  // A channel rejects a glitch when its counter is cleared without an update.
  always_comb begin
    reject_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      reject_s[i] = !differ_s[i] && (cnt_r[i] != '0);
    end
    reject_sum_s = {1'b0, reject_s[0]} + {1'b0, reject_s[1]} + {1'b0, reject_s[2]};
  end

  // Accumulate rejected pulses across all channels; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_count <= 8'd0;
    end else begin
      glitch_count <= sat_add8(glitch_count, reject_sum_s);
    end
  end
`endif

endmodule

// File: tb/tb_spi_input_frontend.sv
// tb_spi_input_frontend
// Directed scenarios followed by randomized pin activity. Every output is
// compared each cycle against a behavioural model. The model accepts a
// level change once the last WAIT synchronized samples all disagree with
// the conditioned level. It counts SCLK rising edges in a frame with an
// unbounded integer.

module tb_spi_input_frontend;

  localparam int WAIT = 3;
  localparam int HL = WAIT + 2;
  localparam logic [2:0] IDLE = 3'b010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_pin = 1'b0;
  logic cs_pin = 1'b1;
  logic mosi_pin = 1'b0;
  logic sclk, cs, mosi, sclk_pos, sclk_neg, cs_fall, cs_rise, mosi_sample, byte_done;
  logic [2:0] bit_count;
`ifdef SPI_GLITCH_COUNT_EN
  logic [7:0] glitch_count;
`endif

  int total = 0;
  int bad = 0;

  // Model state.
  logic [2:0] m_hist [0:HL-1];
  logic [2:0] m_cond;
  logic m_pos, m_neg, m_fall, m_rise, m_msamp, m_byte;
  int m_frame;
  int m_glitch;

  spi_input_frontend #(.WAIT_TIME(WAIT)) dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .sclk(sclk), .cs(cs), .mosi(mosi), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .cs_fall(cs_fall), .cs_rise(cs_rise), .mosi_sample(mosi_sample),
    .bit_count(bit_count), .byte_done(byte_done)
`ifdef SPI_GLITCH_COUNT_EN
    , .glitch_count(glitch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] pins, prev, nxt;
    bit all_diff;
    pins = {mosi_pin, cs_pin, sclk_pin};
    if (reset) begin
      for (int j = 0; j < HL; j++) m_hist[j] = IDLE;
      m_cond = IDLE;
      m_pos = 1'b0; m_neg = 1'b0; m_fall = 1'b0; m_rise = 1'b0;
      m_msamp = 1'b0; m_byte = 1'b0; m_frame = 0; m_glitch = 0;
    end else begin
      prev = m_cond;
      nxt = m_cond;
      for (int ch = 0; ch < 3; ch++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= WAIT; j++) if (m_hist[j][ch] == prev[ch]) all_diff = 1'b0;
        if (all_diff) nxt[ch] = ~prev[ch];
        else if (m_hist[1][ch] == prev[ch] && m_hist[2][ch] != prev[ch]) m_glitch++;
      end
      for (int j = HL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = pins;
      m_pos  = nxt[0] & ~prev[0];
      m_neg  = ~nxt[0] & prev[0];
      m_fall = ~nxt[1] & prev[1];
      m_rise = nxt[1] & ~prev[1];
      if (m_pos) m_msamp = nxt[2];
      m_byte = 1'b0;
      if (nxt[1]) m_frame = 0;
      else if (m_pos) begin
        m_frame++;
        m_byte = (m_frame % 8 == 0);
      end
      m_cond = nxt;
    end
  endtask

  task automatic compare_all();
    int frame_mod;
    frame_mod = m_frame % 8;
    chk("sclk", {7'd0, sclk}, {7'd0, m_cond[0]});
    chk("cs", {7'd0, cs}, {7'd0, m_cond[1]});
    chk("mosi", {7'd0, mosi}, {7'd0, m_cond[2]});
    chk("sclk_pos", {7'd0, sclk_pos}, {7'd0, m_pos});
    chk("sclk_neg", {7'd0, sclk_neg}, {7'd0, m_neg});
    chk("cs_fall", {7'd0, cs_fall}, {7'd0, m_fall});
    chk("cs_rise", {7'd0, cs_rise}, {7'd0, m_rise});
    chk("mosi_sample", {7'd0, mosi_sample}, {7'd0, m_msamp});
    chk("bit_count", {5'd0, bit_count}, 8'(frame_mod));
    chk("byte_done", {7'd0, byte_done}, {7'd0, m_byte});
`ifdef SPI_GLITCH_COUNT_EN
    chk("glitch_count", glitch_count, (m_glitch > 255) ? 8'd255 : 8'(m_glitch));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] pattern;
    logic [7:0] captured;
    int n_fall, n_byte;
    int hold;
    pattern = 8'hA5;

    // Reset, then idle pins for 20 cycles.
    ticks(2);
    reset = 1'b0;
    chk("reset_cs", {7'd0, cs}, 8'd1);
    chk("reset_bit_count", {5'd0, bit_count}, 8'd0);
    ticks(20);

    // SCLK rise latency: visible on the fifth edge after the pin change.
    sclk_pin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_sclk_low", {7'd0, sclk}, 8'd0);
    end
    tick();
    chk("lat_sclk_high", {7'd0, sclk}, 8'd1);
    chk("lat_sclk_pos", {7'd0, sclk_pos}, 8'd1);
    tick();
    chk("lat_sclk_pos_once", {7'd0, sclk_pos}, 8'd0);
    chk("lat_sclk_neg", {7'd0, sclk_neg}, 8'd0);
    sclk_pin = 1'b0;
    ticks(10);

    // Two-cycle MOSI glitch is rejected.
    mosi_pin = 1'b1;
    ticks(2);
    mosi_pin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_mosi_low", {7'd0, mosi}, 8'd0);
    end
`ifdef SPI_GLITCH_COUNT_EN
    chk("glitch_one", glitch_count, 8'd1);
`endif

    // Frame with byte 0xA5, MSB first.
    cs_pin = 1'b0;
    n_fall = 0; n_byte = 0; captured = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cs_fall) n_fall++;
    end
    for (int b = 7; b >= 0; b--) begin
      mosi_pin = pattern[b];
      sclk_pin = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (i == 10) sclk_pin = 1'b1;
        tick();
        if (cs_fall) n_fall++;
        if (byte_done) n_byte++;
        if (sclk_pos) captured = {captured[6:0], mosi_sample};
      end
    end
    chk("frame_cs_fall_once", 8'(n_fall), 8'd1);
    chk("frame_byte_done_once", 8'(n_byte), 8'd1);
    chk("frame_captured", captured, 8'hA5);
    chk("frame_bit_count_wrap", {5'd0, bit_count}, 8'd0);

    // Four more edges, then the fifth coincides with the cs rise.
    for (int p = 0; p < 4; p++) begin
      sclk_pin = 1'b0; ticks(10);
      sclk_pin = 1'b1; ticks(10);
    end
    sclk_pin = 1'b0; ticks(10);
    chk("pre_rise_bit_count", {5'd0, bit_count}, 8'd4);
    sclk_pin = 1'b1;
    cs_pin = 1'b1;
    ticks(5);
    chk("coinc_cs_rise", {7'd0, cs_rise}, 8'd1);
    chk("coinc_sclk_pos", {7'd0, sclk_pos}, 8'd1);
    chk("coinc_bit_count", {5'd0, bit_count}, 8'd0);
    chk("coinc_byte_done", {7'd0, byte_done}, 8'd0);
    sclk_pin = 1'b0; ticks(10);

    // Reset mid-frame at bit_count 3, then restart counting.
    cs_pin = 1'b0; ticks(10);
    for (int p = 0; p < 3; p++) begin
      sclk_pin = 1'b1; ticks(10);
      sclk_pin = 1'b0; ticks(10);
    end
    chk("mid_bit_count", {5'd0, bit_count}, 8'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_cs", {7'd0, cs}, 8'd1);
    chk("mid_reset_bit_count", {5'd0, bit_count}, 8'd0);
    chk("mid_reset_no_rise", {7'd0, cs_rise}, 8'd0);
    n_fall = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cs_fall) n_fall++;
    end
    chk("restart_cs_fall", 8'(n_fall), 8'd1);
    sclk_pin = 1'b1; ticks(10);
    chk("restart_bit_count", {5'd0, bit_count}, 8'd1);
    sclk_pin = 1'b0; ticks(10);

    // Randomized pin activity with occasional resets.
    for (int r = 0; r < 1500; r++) begin
      sclk_pin = 1'($urandom_range(1, 0));
      mosi_pin = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) cs_pin = ~cs_pin;
      reset = ($urandom_range(199, 0) == 0);
      hold = $urandom_range(6, 1);
      ticks(hold);
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
